// File: rtl/hyperbus_target.sv
// HyperBus responder on the SDR view of the DDR bus: decodes the 48-bit CA,
// waits a fixed latency, then serves linear or wrapped bursts from a word array.
module hyperbus_target #(
  parameter int          DEPTH   = 256,
  parameter int          LATENCY = 6,
  parameter int          WRAP    = 16,
  parameter logic [15:0] REG_ID  = 16'h0C81
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  output logic [15:0] dq_o,
  output logic [1:0]  rwds_o,
  output logic        dq_oe,
  output logic        rwds_oe
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = $clog2(LATENCY) + 1;
  localparam logic [AW-1:0] WRAP_MASK = AW'(WRAP - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
  localparam logic [CW-1:0] LAT_LOAD  = CW'(LATENCY - 1);
  localparam logic [CW-1:0] LAT_ONE   = CW'(1);
  localparam logic [CW-1:0] LAT_ZERO  = CW'(0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CA1  = 3'd1,
    S_CA2  = 3'd2,
    S_LAT  = 3'd3,
    S_RD   = 3'd4,
    S_WR   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  // Holds CA[47:16]; CA[15:0] only contributes the low address bits, which go straight into addr_q.
  logic [31:0]     ca_q, ca_d;
  logic [CW-1:0]   lat_q, lat_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            hi_q, hi_d;
  logic [15:0]     dq_d;
  logic [1:0]      rwds_d;
  logic            dq_oe_d, rwds_oe_d;

  logic [15:0]     mem_q [DEPTH];

  logic            is_read_s, is_reg_s, is_lin_s;
  logic [31:0]     wa_s;
  logic [15:0]     rd_word_s;
  logic            wr_en_s;

  assign is_read_s = ca_q[31];
  assign is_reg_s  = ca_q[30];
  assign is_lin_s  = ca_q[29];
  assign wa_s      = {ca_q[28:0], dq_i[2:0]};
  assign wr_en_s   = (state_q == S_WR) && !cs_n && !is_reg_s;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic lin);
    logic [AW-1:0] inc;
    inc = a + ADDR_ONE;
    if (lin) begin
      next_addr = inc;
    end else begin
      next_addr = (a & ~WRAP_MASK) | (inc & WRAP_MASK);
    end
  endfunction

  // Word presented for the next read beat: register space or array.
  always_comb begin
    if (is_reg_s) begin
      rd_word_s = ((addr_q == ADDR_ZERO) && !hi_q) ? REG_ID : 16'h0000;
    end else begin
      rd_word_s = mem_q[addr_q];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cs_n high always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = cs_n ? S_IDLE : S_CA1;
      S_CA1:   state_d = cs_n ? S_IDLE : S_CA2;
      S_CA2:   state_d = cs_n ? S_IDLE : S_LAT;
      S_LAT: begin
        if (cs_n) begin
          state_d = S_IDLE;
        end else if (lat_q == LAT_ZERO) begin
          state_d = is_read_s ? S_RD : S_WR;
        end else begin
          state_d = S_LAT;
        end
      end
      S_RD:    state_d = cs_n ? S_IDLE : S_RD;
      S_WR:    state_d = cs_n ? S_IDLE : S_WR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values registered for the state being entered.
  always_comb begin
    dq_d      = 16'h0000;
    rwds_d    = 2'b00;
    dq_oe_d   = 1'b0;
    rwds_oe_d = 1'b0;
    case (state_d)
      S_CA1, S_CA2, S_LAT: begin
        rwds_oe_d = 1'b1;
      end
      S_RD: begin
        dq_d      = rd_word_s;
        rwds_d    = 2'b10;
        dq_oe_d   = 1'b1;
        rwds_oe_d = 1'b1;
      end
      default: begin
        dq_d      = 16'h0000;
        rwds_oe_d = 1'b0;
      end
    endcase
  end

  // CA capture, latency count and burst address sequencing.
  always_comb begin
    ca_d   = ca_q;
    lat_d  = lat_q;
    addr_d = addr_q;
    hi_d   = hi_q;
    case (state_q)
      S_IDLE: begin
        if (!cs_n) begin
          ca_d[31:16] = dq_i;
        end else begin
          ca_d = ca_q;
        end
      end
      S_CA1: begin
        if (!cs_n) begin
          ca_d[15:0] = dq_i;
        end else begin
          ca_d = ca_q;
        end
      end
      S_CA2: begin
        if (!cs_n) begin
          lat_d  = LAT_LOAD;
          addr_d = wa_s[AW-1:0];
          hi_d   = (wa_s >> AW) != 32'd0;
        end else begin
          lat_d = lat_q;
        end
      end
      S_LAT: begin
        if (cs_n) begin
          lat_d = lat_q;
        end else if (lat_q != LAT_ZERO) begin
          lat_d = lat_q - LAT_ONE;
        end else if (is_read_s) begin
          // First word is registered now, so the pointer moves one beat ahead.
          addr_d = next_addr(addr_q, is_lin_s);
        end else begin
          addr_d = addr_q;
        end
      end
      S_RD, S_WR: begin
        if (!cs_n) begin
          addr_d = next_addr(addr_q, is_lin_s);
        end else begin
          addr_d = addr_q;
        end
      end
      default: begin
        ca_d = ca_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca_q    <= 32'd0;
      lat_q   <= LAT_ZERO;
      addr_q  <= ADDR_ZERO;
      hi_q    <= 1'b0;
      dq_o    <= 16'h0000;
      rwds_o  <= 2'b00;
      dq_oe   <= 1'b0;
      rwds_oe <= 1'b0;
    end else begin
      ca_q    <= ca_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      dq_o    <= dq_d;
      rwds_o  <= rwds_d;
      dq_oe   <= dq_oe_d;
      rwds_oe <= rwds_oe_d;
    end
  end

  // Array write with per-byte masking; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (!rwds_i[1]) begin
        mem_q[addr_q][15:8] <= dq_i[15:8];
      end
      if (!rwds_i[0]) begin
        mem_q[addr_q][7:0] <= dq_i[7:0];
      end
    end
  end

endmodule

// File: doc/hyperbus_target.md
Name: hyperbus_target

Overview:
Synthesizable HyperBus responder (memory-side model) for the far end of the controller's DDR PHY. It operates on the SDR view of the bus: one 16-bit DDR word per clk (two bus edges), as delivered by the bidirectional DDR I/O cell. It decodes the 48-bit command/address, counts a fixed initial latency, then serves linear or wrapped bursts from an internal word array. It also answers register-space reads. It is used as a loopback target in simulation and on FPGA bring-up boards.

Parameters:
DEPTH, 256, number of 16-bit words in the internal array (power of two); AW = log2(DEPTH).
LATENCY, 6, clk cycles between the last CA word and the first data word (must be >= 1).
WRAP, 16, wrapped-burst length in words (power of two, 2..DEPTH).
REG_ID, 16'h0C81, value returned for a register-space read at address 0.

Ports:
clk  input  1  single clock, one DDR word per cycle
rst_n  input  1  asynchronous active-low reset
cs_n  input  1  chip select from controller, sampled on clk
dq_i  input  16  received DDR word; [15:8] = rising-edge byte, [7:0] = falling-edge byte
rwds_i  input  2  received RWDS per edge; [1] rising, [0] falling; 1 = byte masked on write
dq_o  output  16  DDR word to drive, same byte/edge order as dq_i
rwds_o  output  2  RWDS to drive per edge
dq_oe  output  1  DQ output enable
rwds_oe  output  1  RWDS output enable

Behaviour:
- Reset (async, rst_n=0): state IDLE; dq_o=0, rwds_o=0, dq_oe=0, rwds_oe=0, CA register and counters cleared. Array contents are not reset. Reset asserted mid-transaction takes effect immediately.
- States: IDLE, CA1, CA2, LAT, RD, WR.
- IDLE: cs_n=0 -> capture CA[47:32]=dq_i, go to CA1. rwds_oe=1 and rwds_o=2'b00 from CA1 until data phase (fixed single latency).
- CA1 -> CA2: capture CA[31:16]. CA2 -> LAT: capture CA[15:0]; load latency counter with LATENCY-1.
- Decode: CA[47] 1 = read, 0 = write. CA[46] 1 = register space. CA[45] 1 = linear, 0 = wrapped. Word address = {CA[44:16],CA[2:0]}; the low AW bits index the array (modulo DEPTH).
- LAT: decrement each cycle. When counter = 0, go to RD (read) or WR (write).
- On a read, the last LAT cycle registers dq_o <= word at the start address, rwds_o <= 2'b10, dq_oe <= 1. Hence the first data word is on the outputs during the first RD cycle.
- RD: each cycle with cs_n=0, dq_o presents the current address's word and the address advances for the next cycle. rwds_o=2'b10 (toggling strobe).
- WR: each cycle with cs_n=0, the array word at the current address is updated. [15:8] is written unless rwds_i[1]; [7:0] is written unless rwds_i[0]. The address then advances. dq_oe=0 and rwds_oe=0 in WR.
- Address advance: linear = +1 modulo DEPTH. Wrapped = low log2(WRAP) bits +1 modulo WRAP, upper bits held.
- Register space: reads return REG_ID at address 0 and 16'h0000 elsewhere. Writes are accepted and discarded.
- cs_n=1 in any non-IDLE state: next clk returns to IDLE with dq_oe=0, rwds_oe=0, dq_o=0. Words presented in that same cycle are ignored, so no write occurs.
- cs_n held high in IDLE: outputs stay idle. A burst never terminates by itself; length is set only by cs_n.
- cs_n deasserted during CA1/CA2/LAT aborts with no array effect.

Test Plan:
- Linear write of 4 words (CA[47]=0, CA[45]=1, address 0x10) with data 0x1111, 0x2222, 0x3333, 0x4444, then a linear read at 0x10 -> RD returns the same four words in order; first word appears exactly LATENCY+1 cycles after CA2; dq_oe=1 only during RD.
- Masked write to address 0x20 (previously 0xAAAA) of 0x1234 with rwds_i=2'b10 -> readback 0xAA34; with rwds_i=2'b01 -> 0x12AA.
- Wrapped read, WRAP=16, start address 14, array[n]=n -> outputs 14, 15, 0, 1; the same access with CA[45]=1 -> 14, 15, 16, 17.
- Register-space read at address 0 -> 0x0C81; at address 1 -> 0x0000; register write followed by an array read -> array unchanged.
- Write burst to 0x40, cs_n raised after 2 data words -> only 0x40 and 0x41 change; all enables are 0 one cycle later; an immediate new transaction decodes correctly.
- rst_n pulsed low during RD -> dq_oe, rwds_oe and dq_o go to 0 asynchronously; after release, state is IDLE and a new read returns correct data.
